wm_embed: RTL and testbench

//  Downstream consumer of the LFSR watermark generator: takes an 8-bit pixel stream
//  (valid/ready) and the free-running 2-bit watermark symbol, replaces the 2 pixel

---
 rtl/wm_embed.sv | 179 +++++++++++++++++
 tb/tb_wm_embed.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/wm_embed.sv
// wm_embed: replaces the two pixel LSBs with the watermark symbol and frames
// the pixel stream through a 1-deep output register with backpressure.
// Optional feature macro: WM_CHECKSUM_EN adds the wm_checksum output port
// carrying the 16-bit wrapping sum of the symbols embedded in the last frame.
module wm_embed #(
   parameter int PIX_W        = 8,
   parameter int FRAME_PIXELS = 16384,
   parameter int CNT_W        = 14
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic [PIX_W-1:0]  pix_in,
   input  logic              pix_in_valid,
   input  logic              pix_in_sof,
   output logic              pix_in_ready,
   input  logic [1:0]        wm_data,
   output logic [PIX_W-1:0]  pix_out,
   output logic              pix_out_valid,
   output logic              pix_out_sof,
   output logic              pix_out_eof,
   input  logic              pix_out_ready,
   output logic              frame_done,
   output logic [CNT_W-1:0]  pix_count
`ifdef WM_CHECKSUM_EN
   ,
   output logic [15:0]       wm_checksum
`endif
);

   typedef enum logic [0:0] {
      ST_IDLE   = 1'b0,
      ST_ACTIVE = 1'b1
   } state_t;

   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(FRAME_PIXELS - 1);
   localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO = CNT_W'(0);

   // The generator never legally produces 2'b11; such a symbol is neutralised.
   function automatic logic [1:0] sanitize_sym(input logic [1:0] sym);
      return (sym == 2'b11) ? 2'b00 : sym;
   endfunction

   state_t             r_state;
   state_t             w_state_nxt;
   logic [CNT_W-1:0]   r_cnt;
   logic [CNT_W-1:0]   w_cnt_nxt;
   logic [PIX_W-1:0]   r_pix;
   logic               r_valid;
   logic               r_sof;
   logic               r_eof;
   logic               r_done;
   logic               w_acc;
   logic               w_emit;
   logic               w_emit_sof;
   logic               w_eof;
   logic [1:0]         w_sym;

   // Ready is held low while in reset so every output reads 0 during reset.
   assign pix_in_ready = rst_n & (~r_valid | pix_out_ready);
   assign w_acc        = pix_in_valid & pix_in_ready;
   assign w_sym        = sanitize_sym(wm_data);

   assign pix_out       = r_pix;
   assign pix_out_valid = r_valid;
   assign pix_out_sof   = r_sof;
   assign pix_out_eof   = r_eof;
   assign frame_done    = r_done;
   assign pix_count     = r_cnt;

   // Framing FSM: decides whether an accepted pixel is emitted and its sof/eof.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_emit      = 1'b0;
      w_emit_sof  = 1'b0;
      w_eof       = 1'b0;
      if (w_acc) begin
         case (r_state)
            ST_IDLE: begin
               if (pix_in_sof) begin
                  w_emit      = 1'b1;
                  w_emit_sof  = 1'b1;
                  w_cnt_nxt   = CNT_ONE;
                  w_state_nxt = ST_ACTIVE;
               end else begin
                  w_emit      = 1'b0;
               end
            end
            ST_ACTIVE: begin
               w_emit = 1'b1;
               if (pix_in_sof) begin
                  // Early sof truncates the current frame without an eof.
                  w_emit_sof = 1'b1;
                  w_cnt_nxt  = CNT_ONE;
               end else if (r_cnt == LAST_CNT) begin
                  w_eof       = 1'b1;
                  w_cnt_nxt   = CNT_ZERO;
                  w_state_nxt = ST_IDLE;
               end else begin
                  w_cnt_nxt   = r_cnt + CNT_ONE;
               end
            end
            default: begin
               w_state_nxt = ST_IDLE;
               w_cnt_nxt   = CNT_ZERO;
            end
         endcase
      end else begin
         w_emit = 1'b0;
      end
   end

   // State and pixel counter registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
         r_cnt   <= CNT_ZERO;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Output register: load on emit, drop valid when taken with nothing new.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_pix   <= '0;
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
      end else if (w_emit) begin
         r_pix   <= {pix_in[PIX_W-1:2], w_sym};
         r_valid <= 1'b1;
         r_sof   <= w_emit_sof;
         r_eof   <= w_eof;
      end else if (pix_out_ready) begin
         r_valid <= 1'b0;
         r_sof   <= 1'b0;
         r_eof   <= 1'b0;
      end
   end

   // One-cycle pulse after the eof beat is taken downstream.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_done <= 1'b0;
      end else begin
         r_done <= r_valid & pix_out_ready & r_eof;
      end
   end

`ifdef WM_CHECKSUM_EN
   logic [15:0] r_ck_run;
   logic [15:0] r_ck;
   logic [15:0] w_sym16;

   assign w_sym16     = {14'b0, w_sym};
   assign wm_checksum = r_ck;

   // Running symbol sum per frame, latched on the accepted eof pixel.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_ck_run <= 16'h0000;
         r_ck     <= 16'h0000;
      end else if (w_emit) begin
         if (w_emit_sof) begin
            r_ck_run <= w_sym16;
         end else begin
            r_ck_run <= r_ck_run + w_sym16;
         end
         if (w_eof) begin
            r_ck <= r_ck_run + w_sym16;
         end
      end
   end
`endif

endmodule

// File: tb/tb_wm_embed.sv
// Self-checking bench for wm_embed with a 4-pixel frame: directed scenarios
// followed by randomized traffic against a beat-level reference model.
module tb_wm_embed;

   localparam int FP = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b1;
   logic [7:0] pix_in = 8'h00;
   logic       pix_in_valid = 1'b0;
   logic       pix_in_sof = 1'b0;
   logic       pix_in_ready;
   logic [1:0] wm_data = 2'b00;
   logic [7:0] pix_out;
   logic       pix_out_valid;
   logic       pix_out_sof;
   logic       pix_out_eof;
   logic       pix_out_ready = 1'b0;
   logic       frame_done;
   logic [2:0] pix_count;
`ifdef WM_CHECKSUM_EN
   logic [15:0] wm_checksum;
`endif

   wm_embed #(.PIX_W(8), .FRAME_PIXELS(FP), .CNT_W(3)) dut (
      .clk(clk), .rst_n(rst_n),
      .pix_in(pix_in), .pix_in_valid(pix_in_valid), .pix_in_sof(pix_in_sof),
      .pix_in_ready(pix_in_ready), .wm_data(wm_data),
      .pix_out(pix_out), .pix_out_valid(pix_out_valid),
      .pix_out_sof(pix_out_sof), .pix_out_eof(pix_out_eof),
      .pix_out_ready(pix_out_ready), .frame_done(frame_done),
      .pix_count(pix_count)
`ifdef WM_CHECKSUM_EN
      , .wm_checksum(wm_checksum)
`endif
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] d;
      logic       sof;
      logic       eof;
   } beat_t;

   beat_t       q[$];
   int          m_cnt = 0;
   bit          m_in = 1'b0;
   bit          m_done = 1'b0;
   logic [15:0] m_run = 16'h0000;
   logic [15:0] m_ck = 16'h0000;
   int          n_tests = 0;
   int          n_fail = 0;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      q.delete();
      m_cnt  = 0;
      m_in   = 1'b0;
      m_done = 1'b0;
      m_run  = 16'h0000;
      m_ck   = 16'h0000;
   endtask

   // One clock: check state left by the previous edge, drive, predict next edge.
   task automatic step(input bit v, input logic [7:0] p, input bit s,
                       input logic [1:0] w, input bit r);
      bit         take;
      bit         acc;
      bit         exp_rdy;
      logic [1:0] sym;
      beat_t      b;
      check_val("out_valid", 32'(pix_out_valid), 32'(q.size() != 0));
      if (q.size() != 0) begin
         check_val("pix_out", 32'(pix_out), 32'(q[0].d));
         check_val("out_sof", 32'(pix_out_sof), 32'(q[0].sof));
         check_val("out_eof", 32'(pix_out_eof), 32'(q[0].eof));
      end
      check_val("pix_count", 32'(pix_count), 32'(m_cnt));
      check_val("frame_done", 32'(frame_done), 32'(m_done));
`ifdef WM_CHECKSUM_EN
      check_val("wm_checksum", 32'(wm_checksum), 32'(m_ck));
`endif
      pix_in        = p;
      pix_in_valid  = v;
      pix_in_sof    = s;
      wm_data       = w;
      pix_out_ready = r;
      #1;
      exp_rdy = (q.size() == 0) || r;
      check_val("in_ready", 32'(pix_in_ready), 32'(exp_rdy));
      take = (q.size() != 0) && r;
      acc  = v && exp_rdy;
      m_done = 1'b0;
      if (take) begin
         m_done = q[0].eof;
         void'(q.pop_front());
      end
      if (acc) begin
         sym = (w == 2'b11) ? 2'b00 : w;
         b.d = {p[7:2], sym};
         if (s) begin
            b.sof = 1'b1;
            b.eof = 1'b0;
            m_cnt = 1;
            m_in  = 1'b1;
            m_run = 16'(sym);
            q.push_back(b);
         end else if (m_in) begin
            m_cnt = m_cnt + 1;
            m_run = m_run + 16'(sym);
            b.sof = 1'b0;
            b.eof = (m_cnt == FP);
            if (b.eof) begin
               m_ck  = m_run;
               m_cnt = 0;
               m_in  = 1'b0;
            end
            q.push_back(b);
         end
      end
      @(negedge clk);
   endtask

   // Asynchronous reset between clock edges; outputs must clear immediately.
   task automatic do_reset();
      #2;
      rst_n = 1'b0;
      #1;
      check_val("rst_pix_out", 32'(pix_out), 32'h0);
      check_val("rst_valid", 32'(pix_out_valid), 32'h0);
      check_val("rst_sof", 32'(pix_out_sof), 32'h0);
      check_val("rst_eof", 32'(pix_out_eof), 32'h0);
      check_val("rst_done", 32'(frame_done), 32'h0);
      check_val("rst_count", 32'(pix_count), 32'h0);
      check_val("rst_in_ready", 32'(pix_in_ready), 32'h0);
`ifdef WM_CHECKSUM_EN
      check_val("rst_checksum", 32'(wm_checksum), 32'h0);
`endif
      model_reset();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   initial begin
      @(negedge clk);
      do_reset();

      // Idle drops pixels without sof, then sof pixel 8'hFF with symbol 2'b10.
      for (int i = 0; i < 3; i++) step(1'b1, 8'h11, 1'b0, 2'b01, 1'b1);
      check_val("idle_drop_valid", 32'(pix_out_valid), 32'h0);
      step(1'b1, 8'hFF, 1'b1, 2'b10, 1'b1);
      check_val("c2_pix", 32'(pix_out), 32'hFE);
      check_val("c2_sof", 32'(pix_out_sof), 32'h1);
      check_val("c2_count", 32'(pix_count), 32'h1);

      // Early sof at pixel 2 of the frame, then a full 4-pixel frame.
      step(1'b1, 8'h00, 1'b1, 2'b01, 1'b1);
      check_val("early_sof", 32'(pix_out_sof), 32'h1);
      check_val("early_eof", 32'(pix_out_eof), 32'h0);
      check_val("early_count", 32'(pix_count), 32'h1);
      check_val("c3_p0", 32'(pix_out), 32'h01);
      step(1'b1, 8'h01, 1'b0, 2'b10, 1'b1);
      check_val("c3_p1", 32'(pix_out), 32'h02);
      step(1'b1, 8'h02, 1'b0, 2'b00, 1'b1);
      check_val("c3_p2", 32'(pix_out), 32'h00);
      step(1'b1, 8'h03, 1'b0, 2'b11, 1'b1);
      check_val("c3_p3_masked", 32'(pix_out), 32'h00);
      check_val("c3_eof", 32'(pix_out_eof), 32'h1);
      check_val("c3_count_wrap", 32'(pix_count), 32'h0);
      check_val("c3_done_early", 32'(frame_done), 32'h0);
`ifdef WM_CHECKSUM_EN
      check_val("c6_checksum", 32'(wm_checksum), 32'h0003);
`endif
      step(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
      check_val("c3_done", 32'(frame_done), 32'h1);
      step(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
      check_val("c3_done_pulse", 32'(frame_done), 32'h0);

      // Backpressure: 5 stalled cycles with a held pixel, then release.
      step(1'b1, 8'hA4, 1'b1, 2'b01, 1'b1);
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'h5C, 1'b0, 2'b10, 1'b0);
         check_val("stall_pix", 32'(pix_out), 32'hA5);
         check_val("stall_count", 32'(pix_count), 32'h1);
      end
      step(1'b1, 8'h5C, 1'b0, 2'b10, 1'b1);
      check_val("stall_release", 32'(pix_out), 32'h5E);
      check_val("stall_release_cnt", 32'(pix_count), 32'h2);

      // Randomized traffic with one asynchronous reset partway through.
      for (int i = 0; i < 400; i++) begin
         if (i == 200) do_reset();
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 6) == 0,
              2'($urandom), $urandom_range(0, 9) < 7);
      end
      step(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);
      step(1'b0, 8'h00, 1'b0, 2'b00, 1'b1);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
